// File: rtl/memory_stage.sv
// Memory-access stage: word-addressed data memory, write-back source select
// and the MEM/WB pipeline register that feeds the register-file write port.
module memory_stage #(
   parameter int DEPTH = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        reg_write_e,
   input  logic [1:0]  result_src_e,
   input  logic        mem_write_e,
   input  logic [63:0] alu_result,
   input  logic [63:0] write_data,
   input  logic [4:0]  destination_register_e,
   input  logic [63:0] pc_plus4_e,
   output logic [63:0] alu_result_m,
   output logic [63:0] read_data_m,
   output logic        reg_write_w,
   output logic [4:0]  destination_register_w,
   output logic [63:0] result_w
);

   localparam int AW = $clog2(DEPTH);

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] index;
   logic [63:0]   result_sel;

   // Byte offset bits are dropped and upper bits ignored, so addresses
   // wrap modulo DEPTH*8.
   assign index        = alu_result[3 +: AW];
   assign alu_result_m = alu_result;
   assign read_data_m  = mem[index];

   // Store port; memory is deliberately not reset so contents survive a
   // reset, but no write happens while reset is held.
   always_ff @(posedge clock) begin
      if (!reset && mem_write_e && !stall) begin
         mem[index] <= write_data;
      end
   end

   // Write-back source select ahead of the pipeline register.
   always_comb begin
      result_sel = alu_result;
      case (result_src_e)
         2'b01:   result_sel = read_data_m;
         2'b10:   result_sel = pc_plus4_e;
         default: result_sel = alu_result;
      endcase
   end

   // MEM/WB register: reset > stall (hold) > flush (bubble) > load.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         reg_write_w            <= 1'b0;
         destination_register_w <= 5'd0;
         result_w               <= 64'd0;
      end else if (stall) begin
         reg_write_w            <= reg_write_w;
         destination_register_w <= destination_register_w;
         result_w               <= result_w;
      end else if (flush) begin
         reg_write_w            <= 1'b0;
         destination_register_w <= 5'd0;
         result_w               <= 64'd0;
      end else begin
         reg_write_w            <= reg_write_e;
         destination_register_w <= destination_register_e;
         result_w               <= result_sel;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios followed by randomized traffic,
// all compared against a word-array reference model.
module tb_memory_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        reg_write_e = 1'b0;
   logic [1:0]  result_src_e = 2'd0;
   logic        mem_write_e = 1'b0;
   logic [63:0] alu_result = 64'd0;
   logic [63:0] write_data = 64'd0;
   logic [4:0]  destination_register_e = 5'd0;
   logic [63:0] pc_plus4_e = 64'd0;
   logic [63:0] alu_result_m;
   logic [63:0] read_data_m;
   logic        reg_write_w;
   logic [4:0]  destination_register_w;
   logic [63:0] result_w;

   int checks = 0;
   int failures = 0;

   logic [63:0] mdl_mem [256];
   bit          known [256];
   logic        m_rw;
   logic [4:0]  m_rd;
   logic [63:0] m_res;

   memory_stage #(.DEPTH(256)) dut (
      .clock(clock),
      .reset(reset),
      .stall(stall),
      .flush(flush),
      .reg_write_e(reg_write_e),
      .result_src_e(result_src_e),
      .mem_write_e(mem_write_e),
      .alu_result(alu_result),
      .write_data(write_data),
      .destination_register_e(destination_register_e),
      .pc_plus4_e(pc_plus4_e),
      .alu_result_m(alu_result_m),
      .read_data_m(read_data_m),
      .reg_write_w(reg_write_w),
      .destination_register_w(destination_register_w),
      .result_w(result_w)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input logic rw, input logic [1:0] src, input logic mw,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [4:0] rd, input logic [63:0] pc);
      reg_write_e = rw;
      result_src_e = src;
      mem_write_e = mw;
      alu_result = addr;
      write_data = wd;
      destination_register_e = rd;
      pc_plus4_e = pc;
   endtask

   // One pipeline cycle: inputs are already driven just after a rising edge.
   task automatic step();
      int          idx;
      logic [63:0] rd_exp;
      logic [63:0] sel;
      #1;
      idx = int'((alu_result >> 3) % 64'd256);
      rd_exp = mdl_mem[idx];
      chk("alu_result_m", alu_result_m, alu_result);
      if (known[idx]) chk("read_data_m", read_data_m, rd_exp);
      if (result_src_e == 2'd1)      sel = rd_exp;
      else if (result_src_e == 2'd2) sel = pc_plus4_e;
      else                           sel = alu_result;
      if (reset) begin
         m_rw = 1'b0; m_rd = 5'd0; m_res = 64'd0;
         chk("async_rst_rw", {63'd0, reg_write_w}, 64'd0);
         chk("async_rst_rd", {59'd0, destination_register_w}, 64'd0);
         chk("async_rst_res", result_w, 64'd0);
      end
      @(posedge clock);
      if (!reset) begin
         if (mem_write_e && !stall) begin
            mdl_mem[idx] = write_data;
            known[idx] = 1'b1;
         end
         if (!stall) begin
            if (flush) begin
               m_rw = 1'b0; m_rd = 5'd0; m_res = 64'd0;
            end else begin
               m_rw = reg_write_e; m_rd = destination_register_e; m_res = sel;
            end
         end
      end
      #1;
      chk("reg_write_w", {63'd0, reg_write_w}, {63'd0, m_rw});
      chk("dest_reg_w", {59'd0, destination_register_w}, {59'd0, m_rd});
      chk("result_w", result_w, m_res);
   endtask

   initial begin
      m_rw = 1'b0; m_rd = 5'd0; m_res = 64'd0;
      for (int i = 0; i < 256; i++) known[i] = 1'b0;

      #1;
      chk("rst_rw", {63'd0, reg_write_w}, 64'd0);
      chk("rst_rd", {59'd0, destination_register_w}, 64'd0);
      chk("rst_res", result_w, 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Fill every word so later reads have defined contents.
      for (int i = 0; i < 256; i++) begin
         set_op(1'b0, 2'd0, 1'b1, 64'(i) << 3, {$urandom, $urandom}, 5'd0, 64'd0);
         step();
      end

      // Load so reg_write_w is 1, then reset mid-cycle with a store pending.
      set_op(1'b1, 2'd1, 1'b0, 64'h40, 64'd0, 5'd3, 64'd0);
      step();
      chk("pre_reset_rw", {63'd0, reg_write_w}, 64'd1);
      set_op(1'b1, 2'd0, 1'b1, 64'h40, 64'h1234, 5'd4, 64'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;

      set_op(1'b1, 2'd0, 1'b0, 64'd7, 64'd0, 5'd1, 64'd0);
      step();
      chk("add_result", result_w, 64'd7);
      chk("add_rw", {63'd0, reg_write_w}, 64'd1);
      chk("add_rd", {59'd0, destination_register_w}, 64'd1);

      // Word written before reset is retained and the store under reset was dropped.
      set_op(1'b1, 2'd1, 1'b0, 64'h40, 64'd0, 5'd2, 64'd0);
      step();

      // Store then load, including low address bits ignored.
      set_op(1'b0, 2'd0, 1'b1, 64'h18, 64'hDEADBEEFCAFEF00D, 5'd0, 64'd0);
      step();
      set_op(1'b1, 2'd1, 1'b0, 64'h18, 64'd0, 5'd5, 64'd0);
      step();
      chk("load_0x18", result_w, 64'hDEADBEEFCAFEF00D);
      chk("load_0x18_rd", {59'd0, destination_register_w}, 64'd5);
      set_op(1'b1, 2'd1, 1'b0, 64'h19, 64'd0, 5'd6, 64'd0);
      step();
      chk("load_0x19", result_w, 64'hDEADBEEFCAFEF00D);

      // Wrap-around.
      set_op(1'b0, 2'd0, 1'b1, 64'h0, 64'h55, 5'd0, 64'd0);
      step();
      set_op(1'b1, 2'd1, 1'b0, 64'h800, 64'd0, 5'd7, 64'd0);
      step();
      chk("wrap_load", result_w, 64'h55);

      // JAL write-back.
      set_op(1'b1, 2'd2, 1'b0, 64'h999, 64'd0, 5'd1, 64'h104);
      step();
      chk("jal_result", result_w, 64'h104);

      // Stall holds MEM/WB and suppresses the store; release lets it land.
      set_op(1'b1, 2'd0, 1'b1, 64'h20, 64'hAA, 5'd9, 64'd0);
      stall = 1'b1;
      step();
      chk("stall_hold_res", result_w, 64'h104);
      chk("stall_hold_rd", {59'd0, destination_register_w}, 64'd1);
      stall = 1'b0;
      step();
      chk("unstall_rd", {59'd0, destination_register_w}, 64'd9);
      set_op(1'b1, 2'd1, 1'b0, 64'h20, 64'd0, 5'd10, 64'd0);
      step();
      chk("unstall_store", result_w, 64'hAA);

      // Flush, then stall+flush.
      set_op(1'b1, 2'd0, 1'b0, 64'h77, 64'd0, 5'd11, 64'd0);
      flush = 1'b1;
      step();
      chk("flush_rw", {63'd0, reg_write_w}, 64'd0);
      chk("flush_res", result_w, 64'd0);
      flush = 1'b0;
      step();
      set_op(1'b1, 2'd0, 1'b1, 64'h28, 64'hBB, 5'd12, 64'd0);
      stall = 1'b1;
      flush = 1'b1;
      step();
      chk("stall_flush_res", result_w, 64'h77);
      chk("stall_flush_rw", {63'd0, reg_write_w}, 64'd1);
      stall = 1'b0;
      flush = 1'b0;

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         set_op(1'($urandom), 2'($urandom), ($urandom_range(0, 2) == 0),
                {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
                {$urandom, $urandom});
         stall = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 7) == 0);
         reset = ($urandom_range(0, 49) == 0);
         step();
      end
      reset = 1'b0;
      stall = 1'b0;
      flush = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
